bpm_links_demux: RTL and testbench
==================================

Name: bpm_links_demux

Overview:
- Transmit-side counterpart of the BPM link merge path: accepts one 112-bit AXI-Stream of BPM packets and distributes whole packets to two outgoing link streams (M00 = CCW link, M01 = CW link).
- Routing is per packet, decided from the destination field of the header word: port 0, port 1, both (broadcast), or drop.
- Each output has a first-word-fallthrough FIFO with TREADY backpressure, plus per-port packet counters and a drop counter for status readback.

Parameters:
- DW, 112, data width of input and output streams.
- FIFO_DEPTH, 40, words per output FIFO (8 packets of 5 words).
- CNT_W, 16, width of status counters.

Ports:
- ACLK  input  1  single clock for all logic.
- ARESETN  input  1  asynchronous active-low reset.
- S_AXIS_TVALID  input  1  input word valid.
- S_AXIS_TREADY  output  1  input word accepted on TVALID&TREADY.
- S_AXIS_TDATA  input  DW  input word; header word bits [DW-1:DW-2] = destination.
- S_AXIS_TLAST  input  1  last word of packet.
- M00_AXIS_TVALID  output  1  FIFO0 not empty.
- M00_AXIS_TREADY  input  1  pop FIFO0 on TVALID&TREADY.
- M00_AXIS_TDATA  output  DW  head word of FIFO0.
- M00_AXIS_TLAST  output  1  TLAST stored with head word of FIFO0.
- M01_AXIS_TVALID / M01_AXIS_TREADY / M01_AXIS_TDATA / M01_AXIS_TLAST: same, for FIFO1.
- PKT_COUNT0  output  CNT_W  packets (TLAST words) written to FIFO0.
- PKT_COUNT1  output  CNT_W  packets written to FIFO1.
- DROP_COUNT  output  CNT_W  packets discarded (dest 2'b00).

Behaviour:
- Reset (async, ARESETN low): FIFO pointers and occupancy = 0; state = HEAD; route register = 2'b00; all counters = 0; M0x_AXIS_TVALID = 0; S_AXIS_TREADY = 0 while reset is asserted. TDATA/TLAST are don't-care while TVALID = 0. Reset mid-packet discards the partial packet. FIFO RAM contents are not cleared.
- Destination decode (header word only): 2'b01 -> FIFO0; 2'b10 -> FIFO1; 2'b11 -> both; 2'b00 -> drop.
- FIFO storage: DW+1 bits per entry (data + last). Occupancy counter ranges 0..FIFO_DEPTH.
  - full = (occ == FIFO_DEPTH); empty = (occ == 0).
  - Pointers wrap FIFO_DEPTH-1 -> 0. FIFO_DEPTH need not be a power of 2.
- State HEAD:
  - route_now = decode(S_AXIS_TDATA) (combinational).
  - TREADY = 1 if route_now = drop; otherwise TREADY = AND of ~full over the targeted FIFOs.
  - On accept: write the word to the targeted FIFOs and latch the route.
  - If TLAST = 0: go to FWD (route 01/10/11) or DROP (route 00). If TLAST = 1 (single-word packet): stay in HEAD.
- State FWD: TREADY = AND of ~full over the latched targets. Each accepted word is written to all targets. Accepted TLAST -> HEAD.
- State DROP: TREADY = 1; words are discarded. Accepted TLAST -> HEAD.
- Broadcast: a word is accepted only when both FIFOs have space. It is written to both in the same cycle; there is no partial write.
- Full is evaluated on registered occupancy only. A pop in the same cycle does not free space for a push. There is no combinational path from M0x_AXIS_TREADY to S_AXIS_TREADY.
- Simultaneous push and pop on one FIFO: occupancy unchanged, both pointers advance.
- Latency: a word accepted at edge N appears on M0x_AXIS_TDATA with TVALID = 1 after edge N (one cycle). Output TDATA = ram[rd_ptr], first-word-fallthrough.
- Output hold: TVALID stays high until popped. TDATA/TLAST are stable while TVALID & ~TREADY.
- Counters:
  - PKT_COUNTx increments when a word with TLAST = 1 is written to FIFOx; a broadcast increments both.
  - DROP_COUNT increments when TLAST is accepted for a drop packet.
  - All counters wrap modulo 2^CNT_W.
- Input hold: S_AXIS_TDATA and S_AXIS_TLAST must stay stable while TVALID & ~TREADY. The block does not check this.

Test Plan:
- Reset, then a 5-word packet with dest 01 (words 0x..01..05, TLAST on word 5) -> M00 emits the 5 words in order with TLAST on the 5th; M01_TVALID stays 0; PKT_COUNT0 = 1, PKT_COUNT1 = 0.
- 5-word packet with dest 11, M00_TREADY = 1, M01_TREADY held 0 -> after FIFO1 receives 5 words, both outputs hold all 5 words; M00 drains while M01 keeps TVALID = 1 with word 1; PKT_COUNT0 = PKT_COUNT1 = 1.
- 9 dest-10 packets (45 words) with M01_TREADY = 0 -> TREADY drops after 40 words (8 packets), occ1 = 40; release M01_TREADY -> remaining 5 accepted, 45 words emitted in order, pointers wrap correctly.
- Dest 00 packet of 5 words, then a single-word dest 01 packet with TLAST on the header -> TREADY = 1 for all drop words, DROP_COUNT = 1, no output; the single word appears on M00 with TLAST = 1; state returns to HEAD.
- ARESETN pulsed low after word 2 of a dest-01 packet, with 2 words sitting in FIFO0 -> M00_TVALID = 0 immediately, all counters = 0; the next dest-10 packet routes to M01 only, and no stale words appear on M00.
- Back-to-back random packets (all 4 dests, lengths 1–8) with random output TREADY, 10k words -> scoreboard matches per-port order and content; counters match the model.

Source files
------------

// File: rtl/bpm_links_demux.sv
// BPM link demux: routes whole 112-bit packets from one AXI-Stream input to the
// CCW (M00) and CW (M01) link outputs, each buffered by a first-word-fallthrough FIFO.

module bpm_links_fifo #(
  parameter int W     = 113,
  parameter int DEPTH = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Full/empty come from registered occupancy only: a same-cycle pop never frees room for a push.
  assign full_o  = (occ_q == OCC_FULL);
  assign valid_o = (occ_q != '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; validity is tracked by occ_q, so clearing it only costs logic.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule

module bpm_links_demux #(
  parameter int DW         = 112,
  parameter int FIFO_DEPTH = 40,
  parameter int CNT_W      = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic [DW-1:0]    S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  output logic             M00_AXIS_TVALID,
  input  logic             M00_AXIS_TREADY,
  output logic [DW-1:0]    M00_AXIS_TDATA,
  output logic             M00_AXIS_TLAST,
  output logic             M01_AXIS_TVALID,
  input  logic             M01_AXIS_TREADY,
  output logic [DW-1:0]    M01_AXIS_TDATA,
  output logic             M01_AXIS_TLAST,
  output logic [CNT_W-1:0] PKT_COUNT0,
  output logic [CNT_W-1:0] PKT_COUNT1,
  output logic [CNT_W-1:0] DROP_COUNT
);
  typedef enum logic [1:0] {ST_HEAD, ST_FWD, ST_DROP} state_e;

  state_e           state_q;
  logic [1:0]       route_q;
  logic [1:0]       route_now;
  logic [1:0]       targets;
  logic [CNT_W-1:0] pkt_count0_q, pkt_count1_q, drop_count_q;
  logic             full0, full1;
  logic             accept, push0, push1;
  logic [DW:0]      fifo0_dout, fifo1_dout;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    route_now = S_AXIS_TDATA[DW-1:DW-2];
    case (state_q)
      ST_HEAD: targets = route_now;
      ST_FWD:  targets = route_q;
      default: targets = 2'b00;
    endcase
  end

  // Drop traffic is always accepted; otherwise every targeted FIFO must have room.
  assign S_AXIS_TREADY = ARESETN & ~(targets[0] & full0) & ~(targets[1] & full1);
  assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
  assign push0         = accept & targets[0];
  assign push1         = accept & targets[1];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= ST_HEAD;
      route_q      <= 2'b00;
      pkt_count0_q <= '0;
      pkt_count1_q <= '0;
      drop_count_q <= '0;
    end else begin
      if (accept) begin
        case (state_q)
          ST_HEAD: begin
            route_q <= route_now;
            if (!S_AXIS_TLAST) state_q <= (route_now == 2'b00) ? ST_DROP : ST_FWD;
          end
          default: if (S_AXIS_TLAST) state_q <= ST_HEAD;
        endcase
        if (S_AXIS_TLAST && targets == 2'b00) drop_count_q <= drop_count_q + CNT_W'(1);
      end
      if (push0 && S_AXIS_TLAST) pkt_count0_q <= pkt_count0_q + CNT_W'(1);
      if (push1 && S_AXIS_TLAST) pkt_count1_q <= pkt_count1_q + CNT_W'(1);
    end
  end

  bpm_links_fifo #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .push_i  (push0),
    .data_i  ({S_AXIS_TLAST, S_AXIS_TDATA}),
    .pop_i   (M00_AXIS_TREADY),
    .data_o  (fifo0_dout),
    .valid_o (M00_AXIS_TVALID),
    .full_o  (full0)
  );

  bpm_links_fifo #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .push_i  (push1),
    .data_i  ({S_AXIS_TLAST, S_AXIS_TDATA}),
    .pop_i   (M01_AXIS_TREADY),
    .data_o  (fifo1_dout),
    .valid_o (M01_AXIS_TVALID),
    .full_o  (full1)
  );

  assign M00_AXIS_TDATA = fifo0_dout[DW-1:0];
  assign M00_AXIS_TLAST = fifo0_dout[DW];
  assign M01_AXIS_TDATA = fifo1_dout[DW-1:0];
  assign M01_AXIS_TLAST = fifo1_dout[DW];

  assign PKT_COUNT0 = pkt_count0_q;
  assign PKT_COUNT1 = pkt_count1_q;
  assign DROP_COUNT = drop_count_q;
endmodule

// File: tb/tb_bpm_links_demux.sv
// Directed and randomized bench for bpm_links_demux: cycle table, hand sequences
// for backpressure/fill/reset, and a scoreboard run over random packets.

module tb_bpm_links_demux;
  localparam int DW = 112;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m0_valid, m0_ready = 1'b1, m0_last;
  logic          m1_valid, m1_ready = 1'b1, m1_last;
  logic [DW-1:0] m0_data, m1_data;
  logic [15:0]   cnt0, cnt1, cntd;

  int n_checks = 0;
  int n_errors = 0;

  logic        mon_en  = 1'b0;
  logic        rnd_rdy = 1'b0;
  logic [DW:0] exp0[$];
  logic [DW:0] exp1[$];
  logic        m_head = 1'b1;
  logic [1:0]  m_route = 2'b00;
  logic [15:0] m_cnt0 = '0, m_cnt1 = '0, m_drop = '0;

  always #5 clk = ~clk;

  bpm_links_demux #(.DW(DW), .FIFO_DEPTH(40), .CNT_W(16)) dut (
    .ACLK            (clk),
    .ARESETN         (rst_n),
    .S_AXIS_TVALID   (s_valid),
    .S_AXIS_TREADY   (s_ready),
    .S_AXIS_TDATA    (s_data),
    .S_AXIS_TLAST    (s_last),
    .M00_AXIS_TVALID (m0_valid),
    .M00_AXIS_TREADY (m0_ready),
    .M00_AXIS_TDATA  (m0_data),
    .M00_AXIS_TLAST  (m0_last),
    .M01_AXIS_TVALID (m1_valid),
    .M01_AXIS_TREADY (m1_ready),
    .M01_AXIS_TDATA  (m1_data),
    .M01_AXIS_TLAST  (m1_last),
    .PKT_COUNT0      (cnt0),
    .PKT_COUNT1      (cnt1),
    .DROP_COUNT      (cntd)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] d, input logic [15:0] t);
    return {d, 94'd0, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      m0_ready = ($urandom_range(0, 3) != 0);
      m1_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Reference routing: destination taken from the header word only.
  task automatic model_accept(input logic [DW-1:0] d, input logic l);
    if (m_head) m_route = d[DW-1:DW-2];
    if (m_route[0]) begin exp0.push_back({l, d}); if (l) m_cnt0++; end
    if (m_route[1]) begin exp1.push_back({l, d}); if (l) m_cnt1++; end
    if (m_route == 2'b00 && l) m_drop++;
    m_head = l;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic l);
    int waited = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    while (!s_ready && waited < 2000) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      check("send_timeout", s_ready, 1'b1);
      s_valid = 1'b0;
    end else begin
      model_accept(d, l);
      tick();
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check(name, exp0.size() + exp1.size(), 0);
  endtask

  // Output monitor: in-order scoreboard plus hold-stability while stalled.
  logic        hold0 = 1'b0, hold1 = 1'b0;
  logic [DW:0] held0, held1;
  always @(negedge clk) begin
    if (!mon_en) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (hold0) check("m00_hold", {m0_valid, m0_last, m0_data}, {1'b1, held0});
      if (hold1) check("m01_hold", {m1_valid, m1_last, m1_data}, {1'b1, held1});
      if (m0_valid && m0_ready) begin
        if (exp0.size() == 0) check("m00_unexpected", m0_valid, 1'b0);
        else check("m00_word", {m0_last, m0_data}, exp0.pop_front());
      end
      if (m1_valid && m1_ready) begin
        if (exp1.size() == 0) check("m01_unexpected", m1_valid, 1'b0);
        else check("m01_word", {m1_last, m1_data}, exp1.pop_front());
      end
      hold0 = m0_valid & ~m0_ready;
      hold1 = m1_valid & ~m1_ready;
      held0 = {m0_last, m0_data};
      held1 = {m1_last, m1_data};
    end
  end

  typedef struct {
    logic       sv;
    logic [1:0] dest;
    logic [7:0] tag;
    logic       sl;
    logic       r0, r1;
    logic       e_rdy, e_v0;
    logic [7:0] e_t0;
    logic       e_l0, e_v1;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 5-word dest-01 packet, then drop packet (body dest bits ignored), then single-word packet.
    vecs[0]  = '{1'b1, 2'b01, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'b00, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 2'b00, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 2'b10, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'b11, 8'h14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 2'b01, 8'h15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'b01, 8'h21, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h21, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset
    #2 rst_n = 1'b0;
    s_valid = 1'b1;
    #1;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m00_valid", m0_valid, 1'b0);
    check("rst_m01_valid", m1_valid, 1'b0);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_counts", {cnt0, cnt1, cntd}, 48'd0);
    tick();

    // Cycle table
    foreach (vecs[i]) begin
      s_valid  = vecs[i].sv;
      s_data   = mk(vecs[i].dest, {8'h00, vecs[i].tag});
      s_last   = vecs[i].sl;
      m0_ready = vecs[i].r0;
      m1_ready = vecs[i].r1;
      @(negedge clk);
      check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_rdy);
      check($sformatf("vec%0d_m00_valid", i), m0_valid, vecs[i].e_v0);
      check($sformatf("vec%0d_m01_valid", i), m1_valid, vecs[i].e_v1);
      if (vecs[i].e_v0) begin
        check($sformatf("vec%0d_m00_data", i), m0_data[15:0], {8'h00, vecs[i].e_t0});
        check($sformatf("vec%0d_m00_last", i), m0_last, vecs[i].e_l0);
      end
      tick();
    end
    s_valid = 1'b0;
    check("table_pkt0", cnt0, 16'd2);
    check("table_pkt1", cnt1, 16'd0);
    check("table_drop", cntd, 16'd1);
    m_cnt0 = 16'd2; m_cnt1 = 16'd0; m_drop = 16'd1;

    // Broadcast with M01 stalled
    mon_en = 1'b1;
    m0_ready = 1'b1; m1_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      send_word(mk(k == 0 ? 2'b11 : 2'b00, 16'h201 + 16'(k)), k == 4);
    for (int n = 0; n < 50 && exp0.size() != 0; n++) tick();
    @(negedge clk);
    check("bc_m00_drained", m0_valid, 1'b0);
    check("bc_m01_valid", m1_valid, 1'b1);
    check("bc_m01_head", {m1_last, m1_data[15:0]}, {1'b0, 16'h201});
    check("bc_pkt0", cnt0, 16'd3);
    check("bc_pkt1", cnt1, 16'd1);
    tick();
    m1_ready = 1'b1;
    wait_drain("bc_drain");

    // Fill FIFO1 with 8 packets, then stall and release
    m1_ready = 1'b0;
    for (int p = 0; p < 8; p++)
      for (int k = 0; k < 5; k++)
        send_word(mk(k == 0 ? 2'b10 : 2'b01, 16'h300 + 16'(p * 5 + k)), k == 4);
    s_valid = 1'b1; s_data = mk(2'b10, 16'h328); s_last = 1'b0;
    @(negedge clk);
    check("fill_stall_ready", s_ready, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    check("fill_stall_ready_hold", s_ready, 1'b0);
    check("fill_m00_idle", m0_valid, 1'b0);
    check("fill_m01_head", {m1_valid, m1_data[15:0]}, {1'b1, 16'h300});
    tick();
    m1_ready = 1'b1;
    @(negedge clk);
    check("fill_pop_no_free", s_ready, 1'b0);
    for (int k = 0; k < 5; k++)
      send_word(mk(k == 0 ? 2'b10 : 2'b01, 16'h328 + 16'(k)), k == 4);
    wait_drain("fill_drain");
    check("fill_pkt1", cnt1, m_cnt1);

    // Reset mid-packet with two words in FIFO0
    m0_ready = 1'b0;
    send_word(mk(2'b01, 16'h501), 1'b0);
    send_word(mk(2'b01, 16'h502), 1'b0);
    @(negedge clk);
    check("mid_m00_valid", m0_valid, 1'b1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m00_valid", m0_valid, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b0);
    check("mid_rst_counts", {cnt0, cnt1, cntd}, 48'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp0.delete(); exp1.delete();
    m_head = 1'b1; m_route = 2'b00; m_cnt0 = '0; m_cnt1 = '0; m_drop = '0;
    mon_en = 1'b1;
    m0_ready = 1'b1; m1_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++)
      send_word(mk(k == 0 ? 2'b10 : 2'b01, 16'h510 + 16'(k)), k == 2);
    wait_drain("mid_drain");
    @(negedge clk);
    check("mid_m00_empty", m0_valid, 1'b0);
    check("mid_pkt0", cnt0, 16'd0);
    check("mid_pkt1", cnt1, 16'd1);
    check("mid_drop", cntd, 16'd0);
    tick();

    // Random packets against the scoreboard
    rnd_rdy = 1'b1;
    begin
      int words = 0;
      while (words < 10000) begin
        logic [1:0] d;
        int len;
        d   = 2'($urandom_range(0, 3));
        len = $urandom_range(1, 8);
        for (int k = 0; k < len; k++) begin
          logic [1:0] hd;
          hd = (k == 0) ? d : 2'($urandom_range(0, 3));
          send_word({hd, 14'($urandom), $urandom, $urandom, $urandom}, k == len - 1);
          if ($urandom_range(0, 7) == 0) tick();
        end
        words += len;
      end
    end
    rnd_rdy = 1'b0;
    m0_ready = 1'b1; m1_ready = 1'b1;
    wait_drain("rnd_drain");
    @(negedge clk);
    check("rnd_pkt0", cnt0, m_cnt0);
    check("rnd_pkt1", cnt1, m_cnt1);
    check("rnd_drop", cntd, m_drop);
    check("rnd_idle", {m0_valid, m1_valid}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
